// File: rtl/branch_unit.sv
// Multi-cycle conditional-branch evaluator: IDLE -> CMP -> TARGET -> DONE, done on the 3rd edge after start is sampled.
// No backpressure: start is only sampled in IDLE; requests while busy are dropped, giving one branch per 4 cycles.
module branch_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic [XLEN-1:0] pc_actual,
  input  logic [XLEN-1:0] imm,
  output logic            busy,
  output logic            done,
  output logic            taken,
  output logic [XLEN-1:0] pc_next,
  output logic            illegal,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP    = 2'd1,
    TARGET = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] F_BEQ  = 3'b000;
  localparam logic [2:0] F_BNE  = 3'b001;
  localparam logic [2:0] F_BLT  = 3'b100;
  localparam logic [2:0] F_BGE  = 3'b101;
  localparam logic [2:0] F_BLTU = 3'b110;
  localparam logic [2:0] F_BGEU = 3'b111;

  state_t          state;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;

  logic            eq;
  logic            lt;
  logic            ltu;
  logic            taken_d;
  logic            illegal_d;
  logic [XLEN-1:0] target;

  // Decision logic works only on the latched operands, so input changes mid-operation are invisible.
  always_comb begin
    eq        = (rs1_q == rs2_q);
    lt        = ($signed(rs1_q) < $signed(rs2_q));
    ltu       = (rs1_q < rs2_q);
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (funct3_q)
      F_BEQ:   taken_d = eq;
      F_BNE:   taken_d = !eq;
      F_BLT:   taken_d = lt;
      F_BGE:   taken_d = !lt;
      F_BLTU:  taken_d = ltu;
      F_BGEU:  taken_d = !ltu;
      default: illegal_d = 1'b1;
    endcase
    target = taken ? (pc_q + imm_q) : (pc_q + XLEN'(4));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      funct3_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      taken      <= 1'b0;
      pc_next    <= '0;
      illegal    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            funct3_q <= funct3;
            rs1_q    <= RD1;
            rs2_q    <= RD2;
            pc_q     <= pc_actual;
            imm_q    <= imm;
            busy     <= 1'b1;
            state    <= CMP;
          end
        end
        CMP: begin
          taken   <= taken_d;
          illegal <= illegal_d;
          state   <= TARGET;
        end
        TARGET: begin
          pc_next    <= target;
          misaligned <= taken & (target[1:0] != 2'b00);
          done       <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: the driver queues hand-computed results, the monitor checks them on each done pulse.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rd1 = '0;
  logic [31:0] rd2 = '0;
  logic [31:0] pc_actual = '0;
  logic [31:0] imm = '0;
  logic        busy;
  logic        done;
  logic        taken;
  logic [31:0] pc_next;
  logic        illegal;
  logic        misaligned;

  branch_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .funct3     (funct3),
    .RD1        (rd1),
    .RD2        (rd2),
    .pc_actual  (pc_actual),
    .imm        (imm),
    .busy       (busy),
    .done       (done),
    .taken      (taken),
    .pc_next    (pc_next),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
    logic        ill;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest queued result, including its arrival cycle.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: done=1 with no outstanding request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_latency", 64'(cyc), 64'(e.cyc));
        chk("taken", 64'(taken), 64'(e.taken));
        chk("pc_next", 64'(pc_next), 64'(e.pc));
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("misaligned", 64'(misaligned), 64'(e.mis));
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      $display("FAIL idle_timeout: busy still %b after 20 cycles", busy);
    end
  endtask

  // The sampling edge is cyc+1; done is seen after the edge two later, i.e. cyc+3.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] im,
                       input logic et, input logic [31:0] ep, input logic ei, input logic em);
    exp_t e;
    @(negedge clk);
    funct3 = f3; rd1 = a; rd2 = b; pc_actual = pc; imm = im; start = 1'b1;
    e.taken = et; e.pc = ep; e.ill = ei; e.mis = em; e.cyc = cyc + 3;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    funct3 = 3'($urandom); rd1 = $urandom; rd2 = $urandom; pc_actual = $urandom; imm = $urandom;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("hold_taken", 64'(taken), 64'(et));
    chk("hold_pc_next", 64'(pc_next), 64'(ep));
  endtask

  initial begin
    int dcnt;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_taken", 64'(taken), 64'd0);
    chk("rst_pc_next", 64'(pc_next), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_misaligned", 64'(misaligned), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors: funct3, rs1, rs2, pc, imm -> taken, pc_next, illegal, misaligned
    issue(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0100, 32'h0000_0020, 1'b1, 32'h0000_0120, 1'b0, 1'b0);
    issue(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0100, 32'h0000_0020, 1'b0, 32'h0000_0104, 1'b0, 1'b0);
    issue(3'b000, 32'h0000_0005, 32'h0000_0005, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 32'h0000_0010, 1'b0, 1'b0);
    issue(3'b010, 32'h0000_0001, 32'h0000_0002, 32'h0000_0200, 32'h0000_0040, 1'b0, 32'h0000_0204, 1'b1, 1'b0);
    issue(3'b011, 32'h0000_0003, 32'h0000_0003, 32'h0000_0300, 32'h0000_0040, 1'b0, 32'h0000_0304, 1'b1, 1'b0);
    issue(3'b001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0400, 32'h0000_0006, 1'b1, 32'h0000_0406, 1'b0, 1'b1);
    issue(3'b001, 32'h0000_0007, 32'h0000_0007, 32'h0000_0400, 32'h0000_0006, 1'b0, 32'h0000_0404, 1'b0, 1'b0);
    issue(3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0500, 32'hFFFF_FFF0, 1'b1, 32'h0000_04F0, 1'b0, 1'b0);
    issue(3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0500, 32'hFFFF_FFF0, 1'b0, 32'h0000_0504, 1'b0, 1'b0);
    issue(3'b100, 32'h0000_0003, 32'h0000_0003, 32'h0000_0600, 32'h0000_0008, 1'b0, 32'h0000_0604, 1'b0, 1'b0);
    issue(3'b101, 32'h0000_0003, 32'h0000_0003, 32'h0000_0600, 32'h0000_0008, 1'b1, 32'h0000_0608, 1'b0, 1'b0);
    issue(3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0600, 32'h0000_0010, 1'b1, 32'h0000_0610, 1'b0, 1'b0);
    issue(3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0600, 32'h0000_0012, 1'b1, 32'h0000_0612, 1'b0, 1'b1);

    // start held for 10 sampling edges: accepted at S, S+4, S+8; done after S+2, S+6, S+10.
    @(negedge clk);
    funct3 = 3'b000; rd1 = 32'd9; rd2 = 32'd9; pc_actual = 32'h0000_0700; imm = 32'h0000_0010;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.taken = 1'b1; e.pc = 32'h0000_0710; e.ill = 1'b0; e.mis = 1'b0; e.cyc = cyc + 3 + 4 * k;
      q.push_back(e);
    end
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    start = 1'b0;
    chk("b2b_done_count", 64'(dcnt), 64'd2);
    wait_idle();
    repeat (2) @(negedge clk);

    // Abort in TARGET: outputs clear at once, no done pulse follows.
    funct3 = 3'b001; rd1 = 32'd1; rd2 = 32'd2; pc_actual = 32'h0000_0800; imm = 32'h0000_0040;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_in_flight_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_taken", 64'(taken), 64'd0);
    chk("abort_pc_next", 64'(pc_next), 64'd0);
    chk("abort_illegal", 64'(illegal), 64'd0);
    chk("abort_misaligned", 64'(misaligned), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue(3'b001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0800, 32'h0000_0040, 1'b1, 32'h0000_0840, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("outstanding_results", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
